// File: rtl/coin_input_conditioner.sv
// Coin key front end: synchronise and debounce two active-low keys, then arbitrate accepted presses
// into mutually exclusive one-cycle pulses. Optional saturating pulse tallies under `COIN_TALLY_EN.
module coin_input_conditioner #(
    parameter int unsigned CNT_MAX = 20'd1_000_000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_one_n,
    input  logic       key_half_n,
    input  logic       lock,
    output logic       pOne,
    output logic       pHalf,
    output logic [7:0] tally_one,
    output logic [7:0] tally_half
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Index 0 is the 1-yuan key, index 1 the 0.5-yuan key.
    logic [1:0]       key_n;
    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             pend_one_q, pend_one_d;
    logic             pend_half_q, pend_half_d;
    logic             p_one_q, p_one_d;
    logic             p_half_q, p_half_d;

    assign key_n = {key_half_n, key_one_n};
    assign s1_d  = key_n;
    assign s2_d  = s1_q;

    // ev_d marks the cycle in which stable is about to fall; it is registered before arbitration.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            ev_d[i]     = 1'b0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    ev_d[i]     = stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Fixed priority: pend_one, pend_half, ev_one, ev_half; each losing new event becomes pending.
    always_comb begin
        pend_one_d  = pend_one_q;
        pend_half_d = pend_half_q;
        p_one_d     = 1'b0;
        p_half_d    = 1'b0;
        if (lock) begin
            pend_one_d  = 1'b0;
            pend_half_d = 1'b0;
        end else if (pend_one_q) begin
            p_one_d     = 1'b1;
            pend_one_d  = ev_q[0];
            pend_half_d = pend_half_q | ev_q[1];
        end else if (pend_half_q) begin
            p_half_d    = 1'b1;
            pend_half_d = ev_q[1];
            pend_one_d  = ev_q[0];
        end else if (ev_q[0]) begin
            p_one_d     = 1'b1;
            pend_half_d = ev_q[1];
        end else if (ev_q[1]) begin
            p_half_d    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_q        <= 2'b11;
            s2_q        <= 2'b11;
            stable_q    <= 2'b11;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            ev_q        <= 2'b00;
            pend_one_q  <= 1'b0;
            pend_half_q <= 1'b0;
            p_one_q     <= 1'b0;
            p_half_q    <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            stable_q    <= stable_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            ev_q        <= ev_d;
            pend_one_q  <= pend_one_d;
            pend_half_q <= pend_half_d;
            p_one_q     <= p_one_d;
            p_half_q    <= p_half_d;
        end
    end

    assign pOne  = p_one_q;
    assign pHalf = p_half_q;

`ifdef COIN_TALLY_EN
    logic [7:0] tally_one_q, tally_one_d;
    logic [7:0] tally_half_q, tally_half_d;

    // Counts advance on the same edge that registers the pulse and hold at 255.
    always_comb begin
        tally_one_d  = tally_one_q;
        tally_half_d = tally_half_q;
        if (p_one_d && (tally_one_q != 8'd255)) begin
            tally_one_d = tally_one_q + 8'd1;
        end
        if (p_half_d && (tally_half_q != 8'd255)) begin
            tally_half_d = tally_half_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tally_one_q  <= 8'd0;
            tally_half_q <= 8'd0;
        end else begin
            tally_one_q  <= tally_one_d;
            tally_half_q <= tally_half_d;
        end
    end

    assign tally_one  = tally_one_q;
    assign tally_half = tally_half_q;
`else
    assign tally_one  = 8'd0;
    assign tally_half = 8'd0;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: directed scenarios plus randomized key/lock traffic checked
// against a history-window debounce model and an arrival-order coin queue.
module tb_coin_input_conditioner;

    localparam int CNT_MAX = 4;
    localparam int LAT     = CNT_MAX + 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_one_n = 1'b1;
    logic       key_half_n = 1'b1;
    logic       lock = 1'b0;
    logic       pOne, pHalf;
    logic [7:0] tally_one, tally_half;

    int checks = 0;
    int failures = 0;

    coin_input_conditioner #(.CNT_MAX(CNT_MAX), .CNT_W(20)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_one_n  (key_one_n),
        .key_half_n (key_half_n),
        .lock       (lock),
        .pOne       (pOne),
        .pHalf      (pHalf),
        .tally_one  (tally_one),
        .tally_half (tally_half)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model and observation, one pass per rising edge.
    int          cyc = 0;
    logic [31:0] exp_one_q[$], exp_half_q[$], obs_one_q[$], obs_half_q[$];
    int          coin_q[$];
    bit          hist_one[$], hist_half[$];
    bit          stab_one = 1, stab_half = 1, ev_one_p = 0, ev_half_p = 0;
    bit          new_one, new_half, agree;
    int          coin;
    int          both_high = 0;
    int          exp_tally_one = 0, exp_tally_half = 0;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hist_one  = '{1'b1, 1'b1};
            hist_half = '{1'b1, 1'b1};
            stab_one  = 1; stab_half = 1;
            ev_one_p  = 0; ev_half_p = 0;
            coin_q.delete();
            exp_tally_one = 0; exp_tally_half = 0;
        end else begin
            // A level is accepted once the CNT_MAX samples seen through the 2-stage delay all differ from it.
            hist_one.push_back(key_one_n);
            hist_half.push_back(key_half_n);
            if (hist_one.size() > CNT_MAX + 2) void'(hist_one.pop_front());
            if (hist_half.size() > CNT_MAX + 2) void'(hist_half.pop_front());
            new_one = 0; new_half = 0;
            if (hist_one.size() == CNT_MAX + 2) begin
                agree = 1;
                for (int k = 0; k < CNT_MAX; k++) if (hist_one[hist_one.size() - 3 - k] == stab_one) agree = 0;
                if (agree) begin new_one = stab_one; stab_one = !stab_one; end
            end
            if (hist_half.size() == CNT_MAX + 2) begin
                agree = 1;
                for (int k = 0; k < CNT_MAX; k++) if (hist_half[hist_half.size() - 3 - k] == stab_half) agree = 0;
                if (agree) begin new_half = stab_half; stab_half = !stab_half; end
            end
            // Coins wait in arrival order (1-yuan first on a tie) and leave one per cycle.
            if (lock) begin
                coin_q.delete();
            end else begin
                if (ev_one_p) coin_q.push_back(0);
                if (ev_half_p) coin_q.push_back(1);
                if (coin_q.size() > 0) begin
                    coin = coin_q.pop_front();
                    if (coin == 0) begin
                        exp_one_q.push_back(cyc);
`ifdef COIN_TALLY_EN
                        if (exp_tally_one < 255) exp_tally_one++;
`endif
                    end else begin
                        exp_half_q.push_back(cyc);
`ifdef COIN_TALLY_EN
                        if (exp_tally_half < 255) exp_tally_half++;
`endif
                    end
                end
            end
            ev_one_p = new_one; ev_half_p = new_half;
        end
        #1;
        if (pOne === 1'b1) obs_one_q.push_back(cyc);
        if (pHalf === 1'b1) obs_half_q.push_back(cyc);
        if (pOne === 1'b1 && pHalf === 1'b1) both_high++;
        cyc++;
    end

    task automatic test_reset();
        checks++; if (pOne !== 1'b0) begin failures++; $display("FAIL reset_pOne got=%b want=0", pOne); end
        checks++; if (pHalf !== 1'b0) begin failures++; $display("FAIL reset_pHalf got=%b want=0", pHalf); end
        checks++; if (tally_one !== 8'd0) begin failures++; $display("FAIL reset_tally_one got=%0d want=0", tally_one); end
        checks++; if (tally_half !== 8'd0) begin failures++; $display("FAIL reset_tally_half got=%0d want=0", tally_half); end
    endtask

    task automatic test_single_press();
        int o1 = obs_one_q.size(), oh = obs_half_q.size(), t0;
        @(negedge sys_clk); key_half_n = 1'b0; t0 = cyc;
        repeat (20) @(negedge sys_clk);
        key_half_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (obs_half_q.size() - oh != 1) begin
            failures++; $display("FAIL single_count got=%0d want=1", obs_half_q.size() - oh);
        end else begin
            checks++;
            if (obs_half_q[oh] != t0 + LAT) begin failures++; $display("FAIL single_time got=%0d want=%0d", obs_half_q[oh], t0 + LAT); end
        end
        checks++; if (obs_one_q.size() != o1) begin failures++; $display("FAIL single_no_pOne got=%0d want=0", obs_one_q.size() - o1); end
    endtask

    task automatic test_bounce();
        int o1 = obs_one_q.size(), t1;
        @(negedge sys_clk); key_one_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        key_one_n = 1'b1;
        @(negedge sys_clk); key_one_n = 1'b0; t1 = cyc;
        repeat (10) @(negedge sys_clk);
        key_one_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (obs_one_q.size() - o1 != 1) begin
            failures++; $display("FAIL bounce_count got=%0d want=1", obs_one_q.size() - o1);
        end else begin
            checks++;
            if (obs_one_q[o1] != t1 + LAT) begin failures++; $display("FAIL bounce_time got=%0d want=%0d", obs_one_q[o1], t1 + LAT); end
        end
    endtask

    task automatic test_simultaneous();
        int o1 = obs_one_q.size(), oh = obs_half_q.size(), bh = both_high, t0;
        @(negedge sys_clk); key_one_n = 1'b0; key_half_n = 1'b0; t0 = cyc;
        repeat (12) @(negedge sys_clk);
        key_one_n = 1'b1; key_half_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (obs_one_q.size() - o1 != 1 || obs_half_q.size() - oh != 1) begin
            failures++; $display("FAIL simul_count got=%0d/%0d want=1/1", obs_one_q.size() - o1, obs_half_q.size() - oh);
        end else begin
            checks++;
            if (obs_one_q[o1] != t0 + LAT) begin failures++; $display("FAIL simul_one_time got=%0d want=%0d", obs_one_q[o1], t0 + LAT); end
            checks++;
            if (obs_half_q[oh] != t0 + LAT + 1) begin failures++; $display("FAIL simul_half_time got=%0d want=%0d", obs_half_q[oh], t0 + LAT + 1); end
        end
        checks++; if (both_high != bh) begin failures++; $display("FAIL simul_exclusive got=%0d want=0", both_high - bh); end
    endtask

    task automatic test_lock();
        int o1 = obs_one_q.size(), t0;
        @(negedge sys_clk); lock = 1'b1; key_one_n = 1'b0;
        repeat (15) @(negedge sys_clk);
        lock = 1'b0;
        repeat (10) @(negedge sys_clk);
        key_one_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks++; if (obs_one_q.size() != o1) begin failures++; $display("FAIL lock_suppress got=%0d want=0", obs_one_q.size() - o1); end
        key_one_n = 1'b0; t0 = cyc;
        repeat (10) @(negedge sys_clk);
        key_one_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (obs_one_q.size() - o1 != 1) begin
            failures++; $display("FAIL lock_fresh_count got=%0d want=1", obs_one_q.size() - o1);
        end else begin
            checks++;
            if (obs_one_q[o1] != t0 + LAT) begin failures++; $display("FAIL lock_fresh_time got=%0d want=%0d", obs_one_q[o1], t0 + LAT); end
        end
    endtask

    task automatic test_reset_hold();
        int oh = obs_half_q.size(), r;
        @(negedge sys_clk); key_half_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks++; if (pOne !== 1'b0 || pHalf !== 1'b0) begin failures++; $display("FAIL rst_hold_outputs got=%b%b want=00", pOne, pHalf); end
        @(negedge sys_clk); sys_rst_n = 1'b1; r = cyc;
        repeat (12) @(negedge sys_clk);
        key_half_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (obs_half_q.size() - oh != 1) begin
            failures++; $display("FAIL rst_hold_count got=%0d want=1", obs_half_q.size() - oh);
        end else begin
            checks++;
            if (obs_half_q[oh] != r + LAT) begin failures++; $display("FAIL rst_hold_time got=%0d want=%0d", obs_half_q[oh], r + LAT); end
        end
    endtask

    task automatic test_random();
        int o1 = obs_one_q.size(), oh = obs_half_q.size(), e1 = exp_one_q.size(), eh = exp_half_q.size(), bh = both_high;
        int hold_one = 1, hold_half = 1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge sys_clk);
            if (--hold_one == 0) begin key_one_n = ~key_one_n; hold_one = $urandom_range(1, 10); end
            if (--hold_half == 0) begin key_half_n = ~key_half_n; hold_half = $urandom_range(1, 10); end
            lock = ($urandom_range(0, 15) == 0);
        end
        @(negedge sys_clk); key_one_n = 1'b1; key_half_n = 1'b1; lock = 1'b0;
        repeat (20) @(negedge sys_clk);
        checks++;
        if (obs_one_q.size() - o1 != exp_one_q.size() - e1) begin
            failures++; $display("FAIL rand_one_count got=%0d want=%0d", obs_one_q.size() - o1, exp_one_q.size() - e1);
        end else begin
            for (int i = 0; i < exp_one_q.size() - e1; i++) begin
                checks++;
                if (obs_one_q[o1 + i] !== exp_one_q[e1 + i]) begin failures++; $display("FAIL rand_one_time got=%0d want=%0d", obs_one_q[o1 + i], exp_one_q[e1 + i]); end
            end
        end
        checks++;
        if (obs_half_q.size() - oh != exp_half_q.size() - eh) begin
            failures++; $display("FAIL rand_half_count got=%0d want=%0d", obs_half_q.size() - oh, exp_half_q.size() - eh);
        end else begin
            for (int i = 0; i < exp_half_q.size() - eh; i++) begin
                checks++;
                if (obs_half_q[oh + i] !== exp_half_q[eh + i]) begin failures++; $display("FAIL rand_half_time got=%0d want=%0d", obs_half_q[oh + i], exp_half_q[eh + i]); end
            end
        end
        checks++; if (both_high != bh) begin failures++; $display("FAIL rand_exclusive got=%0d want=0", both_high - bh); end
        checks++; if (tally_one !== 8'(exp_tally_one)) begin failures++; $display("FAIL rand_tally_one got=%0d want=%0d", tally_one, exp_tally_one); end
        checks++; if (tally_half !== 8'(exp_tally_half)) begin failures++; $display("FAIL rand_tally_half got=%0d want=%0d", tally_half, exp_tally_half); end
    endtask

    task automatic test_tally();
        int o1;
        logic [7:0] want_one;
        @(negedge sys_clk); sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        o1 = obs_one_q.size();
        for (int n = 0; n < 257; n++) begin
            key_one_n = 1'b0;
            repeat (7) @(negedge sys_clk);
            key_one_n = 1'b1;
            repeat (7) @(negedge sys_clk);
        end
        repeat (10) @(negedge sys_clk);
`ifdef COIN_TALLY_EN
        want_one = 8'd255;
`else
        want_one = 8'd0;
`endif
        checks++; if (obs_one_q.size() - o1 != 257) begin failures++; $display("FAIL tally_pulses got=%0d want=257", obs_one_q.size() - o1); end
        checks++; if (tally_one !== want_one) begin failures++; $display("FAIL tally_one got=%0d want=%0d", tally_one, want_one); end
        checks++; if (tally_one !== 8'(exp_tally_one)) begin failures++; $display("FAIL tally_one_model got=%0d want=%0d", tally_one, exp_tally_one); end
        checks++; if (tally_half !== 8'd0) begin failures++; $display("FAIL tally_half got=%0d want=0", tally_half); end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        test_reset();
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_lock();
        test_reset_hold();
        test_random();
        test_tally();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

Front-end stage for the vending-machine controller. It takes the two raw, bouncing, active-low coin keys, synchronises and debounces each one, and turns every accepted press into a single-cycle pulse on `pOne` or `pHalf`. It also guarantees that the two outputs are never high in the same cycle. The outputs connect directly to the `pOne`/`pHalf` inputs of the downstream vending FSM, which treats every high cycle as one inserted coin.

## Interface
- `CNT_MAX`, default 20'd1_000_000: number of consecutive stable `sys_clk` cycles needed to accept a key change. Legal range is 2 to 2^20−1.
- `CNT_W`, default 20: width of the debounce counters.
- `sys_clk` input 1: clock, `sys_clk`.
- `sys_rst_n` input 1: reset `sys_rst_n`, asynchronous, active-low.
- `key_one_n` input 1: raw 1-yuan key. Asynchronous and active-low (0 = pressed).
- `key_half_n` input 1: raw 0.5-yuan key. Asynchronous and active-low.
- `lock` input 1: coin-refuse request, synchronous to `sys_clk`. While it is 1, accepted presses are discarded.
- `pOne` output 1: one-cycle pulse, meaning one 1-yuan coin accepted.
- `pHalf` output 1: one-cycle pulse, meaning one 0.5-yuan coin accepted.
- `tally_one` output 8: saturating count of `pOne` pulses (see Configuration).
- `tally_half` output 8: saturating count of `pHalf` pulses (see Configuration).

## Operation
- **Per key, synchroniser:** two flip-flops, `s1` then `s2`. Both reset to 1 (idle).
- **Per key, debouncer:** holds a `stable` level (reset value 1) and `cnt[CNT_W-1:0]` (reset value 0).
  - If `s2 == stable`, then `cnt <= 0`.
  - Otherwise, if `cnt == CNT_MAX-1`, then `stable <= s2` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
  - Any glitch shorter than `CNT_MAX` cycles clears the count and causes no change.
- **Events:** `ev_x` is asserted for exactly the one cycle in which `stable` is about to change from 1 to 0 (a press). Releases (0→1) produce no event.
- **Arbiter:** registered. It holds pending flags `pend_one` and `pend_half`, both reset to 0. At each rising edge it issues at most one pulse, using this fixed priority: `pend_one`, then `pend_half`, then `ev_one`, then `ev_half`.
  - The candidate that wins drives its output high for the next cycle. Its pending flag is cleared.
  - Any new event that loses sets its pending flag.
  - Because presses on one key are at least `CNT_MAX` ≥ 2 cycles apart, a pending flag is never set while it is already set. No coin is ever lost.
- **`lock` = 1:** `ev_one`/`ev_half` are discarded, both pending flags are cleared, and `pOne` = `pHalf` = 0. The debouncers keep running, so a key held down during lock does not fire when `lock` falls.
- **Outputs without lock:** `pOne` and `pHalf` are mutually exclusive in every cycle. Each pulse is exactly 1 cycle wide.

## Timing
- **Reset values:** `pOne`=0, `pHalf`=0, `tally_one`=0, `tally_half`=0. All internal state takes the values stated above.
- **Latency:** a raw key falls and stays low from before edge E0 with no contention. Then:
  - `s2` = 0 after E1.
  - `stable` falls at E(1+`CNT_MAX`).
  - The output pulse is high in the cycle after E(2+`CNT_MAX`).
- **Simultaneous presses:** if `ev_one` and `ev_half` occur in the same cycle, `pOne` is high first and `pHalf` is high in the very next cycle.
- **Pending versus new event:** a pending flag always drains before any new event. For example, with `pend_half` set and a new `ev_one` arriving, the output is `pHalf` followed by `pOne`.
- **Reset in the middle of a press:** all state returns to idle. If a key is still held low when reset is released, it debounces again from `cnt`=0 and produces exactly one pulse `CNT_MAX`+2 edges after release.
- **Key released before acceptance:** if the key is released with `cnt < CNT_MAX-1`, there is no pulse.

## Configuration
- **Macro:** `COIN_TALLY_EN`.
- **Defined:**
  - `tally_one` increments on each `pOne` pulse, in the same edge that registers the pulse.
  - `tally_half` increments on each `pHalf` pulse in the same way.
  - Both counters saturate at 8'd255.
  - Both counters are cleared only by reset.
- **Undefined:** `tally_one` and `tally_half` are tied to 8'd0 and no counter logic is built. The ports remain present.

## Test plan
- **Single clean press:** with `CNT_MAX`=4, hold `key_half_n`=0 for 20 cycles. Require `pHalf` high for exactly 1 cycle, 6 edges after the first sampling edge. Require `pOne`=0 throughout.
- **Bounce rejection:** with `CNT_MAX`=4, drive `key_one_n` low for 3 cycles, high for 1, then low for 10. Require exactly one `pOne` pulse, timed from the start of the final low period. Require no pulse from the 3-cycle glitch.
- **Simultaneous press:** press both keys on the same edge. Require `pOne` high in cycle N, `pHalf` high in cycle N+1, and never both high together.
- **Lock:** hold `lock`=1 while pressing `key_one_n`, then drop `lock` while the key is still held. Require no `pOne` pulse. A fresh press after release must pulse normally.
- **Reset during hold:** hold `key_half_n`=0, pulse `sys_rst_n` low mid-count, then release reset. Require outputs = 0 during reset and exactly one `pHalf` pulse `CNT_MAX`+2 edges after release.
- **Tally (`COIN_TALLY_EN`):** issue 257 `pOne` presses. Require `tally_one` = 255 (saturated) and `tally_half` = 0. Without the macro, require both tallies = 0.
